mips_harvard_bus_arbiter: RTL

- Shares one single-port Avalon-style memory bus between the Harvard CPU's instruction port and data port.
- Per CPU cycle: performs the instruction fetch, then the data access if one is requested, then pulses cpu_clk_enable for exactly one clock so the CPU commits.
- Presents latched fetch/read data to the CPU as combinational-looking readdata.
- Sits between mips_cpu_harvard and the system memory/interconnect.

---
 rtl/mips_harvard_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mips_harvard_bus_arbiter.sv
// Time-multiplexes the Harvard CPU's instruction and data ports onto one Avalon-style bus,
// then strobes cpu_clk_enable for one clock so the CPU commits the instruction.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | post-reset settle, RESET_IDLE cycles
// S_FETCH  | instruction read on the bus
// S_DATA   | load/store on the bus (store wins if both requested)
// S_COMMIT | one-clock cpu_clk_enable, bus idle
// S_HALT   | CPU inactive, absorbing until reset
// S_ERROR  | waitrequest timeout, absorbing until reset
module mips_harvard_bus_arbiter #(
  parameter int WAIT_LIMIT = 16,
  parameter int RESET_IDLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [3:0]  cpu_data_byteenable,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error,
  output logic        halted
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_COMMIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t         state;
  logic [3:0]     idle_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           data_req;
  logic           wait_hit;

  assign data_req = cpu_data_read | cpu_data_write;
  // Terminal wait cycle: this stalled cycle is the WAIT_LIMIT-th in a row.
  assign wait_hit = mem_waitrequest && (wait_cnt == WCW'(WAIT_LIMIT - 1));

  // Bus requests follow the state directly so an async reset drops them instantly.
  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    case (state)
      S_FETCH: begin
        if (cpu_active) begin
          mem_read       = 1'b1;
          mem_address    = cpu_instr_address;
          mem_byteenable = 4'hF;
        end
      end
      S_DATA: begin
        mem_address = cpu_data_address;
        if (cpu_data_write) begin
          mem_write      = 1'b1;
          mem_byteenable = cpu_data_byteenable;
          mem_writedata  = cpu_data_writedata;
        end else if (cpu_data_read) begin
          mem_read       = 1'b1;
          mem_byteenable = 4'hF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      idle_cnt           <= '0;
      wait_cnt           <= '0;
      cpu_instr_readdata <= '0;
      cpu_data_readdata  <= '0;
      cpu_clk_enable     <= 1'b0;
      bus_error          <= 1'b0;
      halted             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_cnt == 4'(RESET_IDLE - 1)) begin
            state    <= S_FETCH;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
          end
        end
        S_FETCH: begin
          if (!cpu_active) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!mem_waitrequest) begin
            cpu_instr_readdata <= mem_readdata;
            wait_cnt           <= '0;
            if (data_req) begin
              state <= S_DATA;
            end else begin
              state          <= S_COMMIT;
              cpu_clk_enable <= 1'b1;
            end
          end else if (wait_hit) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_DATA: begin
          if (!mem_waitrequest) begin
            if (cpu_data_read && !cpu_data_write) cpu_data_readdata <= mem_readdata;
            wait_cnt       <= '0;
            state          <= S_COMMIT;
            cpu_clk_enable <= 1'b1;
          end else if (wait_hit) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_COMMIT: begin
          cpu_clk_enable <= 1'b0;
          state          <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule
